// File: rtl/score_collector.sv
// Double-buffered serial-to-parallel score collector: gathers one signed score per class
// into a collect buffer and presents completed frames from a stable hold buffer.
module score_collector #(
  parameter int NUM_CLASSES = 10,
  parameter int W           = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [W-1:0]                       in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_CLASSES*W-1:0]           out_data,
  output logic [$clog2(NUM_CLASSES+1)-1:0]   out_len,
  output logic                               short_pls,
  output logic                               err_nolast,
  input  logic                               clr_err,
  output logic [15:0]                        frame_cnt
);

  localparam int LW = $clog2(NUM_CLASSES + 1);
  localparam logic [W-1:0] MIN_SCORE = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {COLLECT, PENDING} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [W-1:0]  coll_q [NUM_CLASSES];
  logic [W-1:0]  coll_d [NUM_CLASSES];
  logic [W-1:0]  hold_q [NUM_CLASSES];
  logic [W-1:0]  hold_d [NUM_CLASSES];
  logic [LW-1:0] out_len_q, out_len_d;
  logic          out_valid_q, out_valid_d;
  logic          short_q, short_d;
  logic          err_q, err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic accept, close, transfer;

  assign in_ready = (state_q == COLLECT);
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || (cnt_q == LW'(NUM_CLASSES - 1)));
  assign transfer = (state_q == PENDING) && (!out_valid_q || out_ready);

  // NOTE: every signal written here gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    coll_d      = coll_q;
    hold_d      = hold_q;
    out_len_d   = out_len_q;
    out_valid_d = out_valid_q;
    short_d     = 1'b0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;

    if (clr_err) err_d = 1'b0;

    if (accept) begin
      coll_d[cnt_q] = in_data;
      cnt_d         = cnt_q + 1'b1;
    end

    if (close) begin
      state_d = PENDING;
      len_d   = cnt_q + 1'b1;
      cnt_d   = '0;
      // Reaching the full count without in_last overrides a same-cycle clear.
      if (!in_last) err_d = 1'b1;
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (transfer) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        hold_d[i] = (LW'(i) < len_q) ? coll_q[i] : MIN_SCORE;
      end
      out_len_d   = len_q;
      out_valid_d = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
      short_d     = (len_q < LW'(NUM_CLASSES));
      state_d     = COLLECT;
      cnt_d       = '0;
    end
  end

  // NOTE: state uses non-blocking assignments only, so every flop samples the values
  // computed from the previous cycle regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      len_q       <= '0;
      out_len_q   <= '0;
      out_valid_q <= 1'b0;
      short_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      // NOTE: both score buffers are reset, unlike plain storage, so out_data reads 0
      // and no partial frame survives a reset.
      for (int i = 0; i < NUM_CLASSES; i++) begin
        coll_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      coll_q      <= coll_d;
      hold_q      <= hold_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
      short_q     <= short_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_CLASSES; i++) out_data[i*W +: W] = hold_q[i];
  end

  assign out_valid  = out_valid_q;
  assign out_len    = out_len_q;
  assign short_pls  = short_q;
  assign err_nolast = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_score_collector.sv
// Self-checking bench for score_collector: table-driven frames with a scoreboard of
// expected hold-buffer contents, plus hand sequences for error, backpressure, reset, wrap.
module tb_score_collector;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int LW = $clog2(N + 1);
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_len;
  logic          short_pls, err_nolast, clr_err;
  logic [15:0]   frame_cnt;

  score_collector #(.NUM_CLASSES(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len),
    .short_pls(short_pls), .err_nolast(err_nolast), .clr_err(clr_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int            n;
    logic [DW-1:0] beats;
    int            exp_len;
    bit            exp_short;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LW-1:0] len;
  } frame_t;

  localparam int NV = 6;
  vec_t   tbl [NV];
  frame_t sb_q [$];
  int     total = 0;
  int     bad = 0;
  int     short_cnt = 0;
  logic [15:0] exp_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_frame(input logic [DW-1:0] beats, input int len);
    logic [DW-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = (i < len) ? beats[i*W +: W] : 32'h8000_0000;
    return f;
  endfunction

  task automatic push_exp(input logic [DW-1:0] beats, input int len);
    frame_t e;
    e.data = make_frame(beats, len);
    e.len  = LW'(len);
    sb_q.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready stayed 0, need 1");
        break;
      end
    end
    idle();
  endtask

  task automatic send_frame(input logic [DW-1:0] beats, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) send_beat(beats[i*W +: W], last_at_end && (i == n - 1));
  endtask

  // Scoreboard: a frame is consumed on the edge following a negedge with valid && ready.
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: frame len %0d delivered, none expected", out_len);
        end else begin
          e = sb_q.pop_front();
          check_wide("sb_data", out_data, e.data);
          check("sb_len", 32'(out_len), 32'(e.len));
        end
      end
    end
  end

  always @(negedge clk) if (short_pls) short_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] fa, fb, fx;
    int s0;

    for (int v = 0; v < NV; v++) tbl[v] = '0;
    tbl[0].n = 10; tbl[0].exp_len = 10; tbl[0].exp_short = 1'b0;
    for (int i = 0; i < 10; i++) tbl[0].beats[i*W +: W] = 32'(i * 100);
    tbl[1].n = 4; tbl[1].exp_len = 4; tbl[1].exp_short = 1'b1;
    tbl[1].beats[0*W +: W] = 32'(5);
    tbl[1].beats[1*W +: W] = 32'(-3);
    tbl[1].beats[2*W +: W] = 32'(7);
    tbl[1].beats[3*W +: W] = 32'(2);
    tbl[2].n = 4; tbl[2].exp_len = 4; tbl[2].exp_short = 1'b1;
    tbl[2].beats[0*W +: W] = 32'h8000_0000;
    tbl[2].beats[1*W +: W] = 32'h7FFF_FFFF;
    tbl[2].beats[2*W +: W] = 32'hFFFF_FFFF;
    tbl[2].beats[3*W +: W] = 32'h0000_0000;
    tbl[3].n = 1; tbl[3].exp_len = 1; tbl[3].exp_short = 1'b1;
    tbl[3].beats[0*W +: W] = 32'(42);
    tbl[4].n = 9; tbl[4].exp_len = 9; tbl[4].exp_short = 1'b1;
    for (int i = 0; i < 9; i++) tbl[4].beats[i*W +: W] = 32'(i * 7 - 30);
    tbl[5].n = 10; tbl[5].exp_len = 10; tbl[5].exp_short = 1'b0;
    for (int i = 0; i < 10; i++) tbl[5].beats[i*W +: W] = $urandom;

    rst = 1'b0; out_ready = 1'b1; clr_err = 1'b0; idle();
    exp_fc = '0;
    wait_cycles(3);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check_wide("rst_out_data", out_data, '0);
    check("rst_out_len", 32'(out_len), 32'(0));
    check("rst_short", 32'(short_pls), 32'(0));
    check("rst_err", 32'(err_nolast), 32'(0));
    check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    rst = 1'b1;
    wait_cycles(1);
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Latency: closing beat at edge E, frame visible after E+1, gone after E+2.
    fx = '0;
    fx[0 +: W] = 32'(55);
    push_exp(fx, 1);
    send_beat(32'(55), 1'b1);
    check("lat_valid_e", 32'(out_valid), 32'(0));
    check("lat_ready_e", 32'(in_ready), 32'(0));
    wait_cycles(1);
    exp_fc++;
    check("lat_valid_e1", 32'(out_valid), 32'(1));
    check("lat_ready_e1", 32'(in_ready), 32'(1));
    check("lat_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    wait_cycles(1);
    check("lat_valid_e2", 32'(out_valid), 32'(0));

    for (int v = 0; v < NV; v++) begin
      s0 = short_cnt;
      push_exp(tbl[v].beats, tbl[v].exp_len);
      send_frame(tbl[v].beats, tbl[v].n, 1'b1);
      exp_fc++;
      wait_cycles(3);
      check("tbl_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      check("tbl_short", short_cnt - s0, 32'(tbl[v].exp_short));
      check("tbl_err", 32'(err_nolast), 32'(0));
      check("tbl_sb_drained", sb_q.size(), 0);
    end

    // Missing in_last: closes at 10, overflow beats start the next frame at index 0.
    fx = '0;
    for (int i = 0; i < 10; i++) fx[i*W +: W] = 32'(i + 1);
    push_exp(fx, 10);
    fx = '0;
    fx[0*W +: W] = 32'(11); fx[1*W +: W] = 32'(12); fx[2*W +: W] = 32'(13);
    push_exp(fx, 3);
    for (int i = 1; i <= 10; i++) send_beat(32'(i), 1'b0);
    check("nolast_err_set", 32'(err_nolast), 32'(1));
    send_beat(32'(11), 1'b0);
    send_beat(32'(12), 1'b0);
    send_beat(32'(13), 1'b1);
    exp_fc += 16'd2;
    wait_cycles(3);
    check("nolast_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    check("nolast_err_sticky", 32'(err_nolast), 32'(1));
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    check("nolast_err_clr", 32'(err_nolast), 32'(0));

    // Clear and new error on the same edge: error wins.
    fx = '0;
    for (int i = 0; i < 10; i++) fx[i*W +: W] = 32'(200 + i);
    push_exp(fx, 10);
    clr_err = 1'b1;
    send_frame(fx, 10, 1'b0);
    check("errwin_set", 32'(err_nolast), 32'(1));
    clr_err = 1'b0;
    exp_fc++;
    wait_cycles(3);
    check("errwin_sticky", 32'(err_nolast), 32'(1));
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    check("errwin_clr", 32'(err_nolast), 32'(0));

    // Backpressure: A held, B waits complete in collect, in_ready low.
    fa = '0;
    fa[0*W +: W] = 32'(11); fa[1*W +: W] = 32'(22); fa[2*W +: W] = 32'(33);
    fb = '0;
    fb[0*W +: W] = 32'(44); fb[1*W +: W] = 32'(55);
    out_ready = 1'b0;
    push_exp(fa, 3);
    push_exp(fb, 2);
    send_frame(fa, 3, 1'b1);
    wait_cycles(2);
    check("bp_a_valid", 32'(out_valid), 32'(1));
    check_wide("bp_a_data", out_data, make_frame(fa, 3));
    check("bp_a_len", 32'(out_len), 32'(3));
    send_frame(fb, 2, 1'b1);
    wait_cycles(3);
    check("bp_in_ready_low", 32'(in_ready), 32'(0));
    check_wide("bp_a_stable", out_data, make_frame(fa, 3));
    check("bp_a_len_stable", 32'(out_len), 32'(3));
    check("bp_frame_cnt_a", 32'(frame_cnt), 32'(exp_fc + 16'd1));
    out_ready = 1'b1;
    wait_cycles(1);
    exp_fc += 16'd2;
    check("bp_b_valid", 32'(out_valid), 32'(1));
    check_wide("bp_b_data", out_data, make_frame(fb, 2));
    check("bp_b_len", 32'(out_len), 32'(2));
    check("bp_frame_cnt_b", 32'(frame_cnt), 32'(exp_fc));
    check("bp_in_ready_back", 32'(in_ready), 32'(1));
    wait_cycles(2);
    check("bp_sb_drained", sb_q.size(), 0);

    // Reset mid-frame with a frame sitting in hold.
    out_ready = 1'b0;
    fx = '0;
    fx[0*W +: W] = 32'(9); fx[1*W +: W] = 32'(8);
    send_frame(fx, 2, 1'b1);
    wait_cycles(2);
    check("mr_hold_loaded", 32'(out_valid), 32'(1));
    for (int i = 1; i <= 5; i++) send_beat(32'(i), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'(0));
    check_wide("mr_out_data", out_data, '0);
    check("mr_out_len", 32'(out_len), 32'(0));
    check("mr_frame_cnt", 32'(frame_cnt), 32'(0));
    check("mr_short", 32'(short_pls), 32'(0));
    wait_cycles(2);
    rst = 1'b1;
    out_ready = 1'b1;
    exp_fc = '0;
    wait_cycles(1);
    check("mr_in_ready", 32'(in_ready), 32'(1));
    fx = '0;
    fx[0*W +: W] = 32'(77); fx[1*W +: W] = 32'(88);
    push_exp(fx, 2);
    send_frame(fx, 2, 1'b1);
    exp_fc++;
    wait_cycles(3);
    check("mr_frame_cnt_after", 32'(frame_cnt), 32'(exp_fc));
    check("mr_sb_drained", sb_q.size(), 0);

    // frame_cnt wrap from a preloaded 0xFFFF, reusing the extremes frame.
    force dut.frame_cnt_q = 16'hFFFF;
    wait_cycles(1);
    release dut.frame_cnt_q;
    wait_cycles(1);
    check("wrap_preload", 32'(frame_cnt), 32'h0000_FFFF);
    push_exp(tbl[2].beats, 4);
    send_frame(tbl[2].beats, 4, 1'b1);
    wait_cycles(3);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'(0));

    wait_cycles(5);
    check("final_sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
